// File: rtl/sh4_fpu_fdiv_seq.sv
// sh4_fpu_fdiv_seq: iterative single-precision divider (restoring, radix 2^ITER_BITS) with rounding and FPSCR cause flags
//  clk, rst (async, active-high), flush (sync abort)
//  in_valid/in_ready: operand handshake; a_*/b_*: expanded operands (sign, unbiased 9-bit exp, frac, class flags); rm: 0=RNE 1=RZ
//  out_valid/out_ready: result handshake; out_result: packed IEEE single; out_flag_dz/out_flag_inv: cause flags
module sh4_fpu_fdiv_seq #(
    parameter int ITER_BITS = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        a_sign,
    input  logic [8:0]  a_exp,
    input  logic [22:0] a_frac,
    input  logic        a_is_zero,
    input  logic        a_is_inf,
    input  logic        a_is_nan,
    input  logic        b_sign,
    input  logic [8:0]  b_exp,
    input  logic [22:0] b_frac,
    input  logic        b_is_zero,
    input  logic        b_is_inf,
    input  logic        b_is_nan,
    input  logic        rm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_flag_dz,
    output logic        out_flag_inv
);
    typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} state_t;
    localparam logic [4:0] LAST = 5'(26 / ITER_BITS - 1);
    state_t      state;
    logic [25:0] rem, q, r_n, q_n;
    logic [23:0] dvs;
    logic [4:0]  cnt;
    logic [10:0] e, eb;
    logic        s, rm_q;
    logic        a_z, b_z, s_in, special, sp_inv, sp_dz;
    logic [31:0] sp_res, rnd_res;
    logic        norm, guard, sticky, inc, ovf, unf;
    logic [23:0] m0, mant;
    logic [24:0] m1;
    // Denormals are flushed to signed zero before classification.
    always_comb begin
        a_z     = a_is_zero | (a_exp == 9'h181);
        b_z     = b_is_zero | (b_exp == 9'h181);
        s_in    = a_sign ^ b_sign;
        special = a_is_nan | b_is_nan | a_z | b_z | a_is_inf | b_is_inf;
        sp_inv  = a_is_nan | b_is_nan | (a_z & b_z) | (a_is_inf & b_is_inf);
        sp_dz   = ~sp_inv & b_z;
        sp_res  = sp_inv ? 32'h7FBFFFFF :
                  (b_z | a_is_inf) ? {s_in, 8'hFF, 23'h0} : {s_in, 31'h0};
    end
    // Restoring division steps; the partial remainder stays below 2*divisor.
    always_comb begin
        r_n = rem;
        q_n = q;
        for (int i = 0; i < ITER_BITS; i++) begin
            q_n = {q_n[24:0], r_n >= {2'b0, dvs}};
            r_n = (q_n[0] ? r_n - {2'b0, dvs} : r_n) << 1;
        end
    end
    // Quotient lies in (0.5, 2): normalise by at most one left shift, then round.
    always_comb begin
        norm    = q[25];
        m0      = norm ? q[25:2] : q[24:1];
        guard   = norm ? q[1] : q[0];
        sticky  = (norm & q[0]) | (rem != 26'd0);
        inc     = ~rm_q & guard & (sticky | m0[0]);
        m1      = {1'b0, m0} + {24'd0, inc};
        mant    = m1[24] ? m1[24:1] : m1[23:0];
        eb      = e - {10'd0, ~norm} + {10'd0, m1[24]} + 11'd127;
        ovf     = $signed(eb) >= 11'sd255;
        unf     = $signed(eb) <= 11'sd0;
        rnd_res = ovf ? (rm_q ? {s, 31'h7F7FFFFF} : {s, 8'hFF, 23'h0}) :
                  unf ? {s, 31'h0} : {s, eb[7:0], mant[22:0]};
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            out_result   <= 32'h0;
            out_flag_dz  <= 1'b0;
            out_flag_inv <= 1'b0;
            rem          <= 26'd0;
            q            <= 26'd0;
            dvs          <= 24'd0;
            cnt          <= 5'd0;
            e            <= 11'd0;
            s            <= 1'b0;
            rm_q         <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    in_ready <= 1'b0;
                    s        <= s_in;
                    rm_q     <= rm;
                    if (special) begin
                        out_result   <= sp_res;
                        out_flag_inv <= sp_inv;
                        out_flag_dz  <= sp_dz;
                        out_valid    <= 1'b1;
                        state        <= DONE;
                    end else begin
                        rem   <= {3'b001, a_frac};
                        dvs   <= {1'b1, b_frac};
                        q     <= 26'd0;
                        cnt   <= 5'd0;
                        e     <= {{2{a_exp[8]}}, a_exp} - {{2{b_exp[8]}}, b_exp};
                        state <= DIV;
                    end
                end
                DIV: begin
                    rem <= r_n;
                    q   <= q_n;
                    cnt <= cnt + 5'd1;
                    if (cnt == LAST) state <= ROUND;
                end
                ROUND: begin
                    out_result   <= rnd_res;
                    out_flag_inv <= 1'b0;
                    out_flag_dz  <= 1'b0;
                    out_valid    <= 1'b1;
                    state        <= DONE;
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule
